// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing the single L2 port between I-cache and D-cache.
// Optional perf counters are enabled with the L2_ARB_PERF_EN macro.
module l2_rr_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int FIXED_D_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] line_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
`ifdef L2_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t state;
    logic   last_d;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    assign d_req = d_read | d_write;

    // Pick a winner in IDLE; on a tie the side that did not win last goes next.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_read && d_req) begin
                grant_d = (FIXED_D_PRIO != 0) || !last_d;
                grant_i = !grant_d;
            end else begin
                grant_i = i_read;
                grant_d = d_req;
            end
        end
    end

    // Sequencer: latch the winner's command at grant, hold it until l2_resp.
    // A read+write from D is treated as a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= 1'b1;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= SERVE_D;
                        last_d   <= 1'b1;
                        l2_read  <= d_read;
                        l2_write <= ~d_read;
                        l2_addr  <= d_addr;
                        l2_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state    <= SERVE_I;
                        last_d   <= 1'b0;
                        l2_read  <= 1'b1;
                        l2_write <= 1'b0;
                        l2_addr  <= i_addr;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_resp) begin
                        state    <= IDLE;
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    l2_read  <= 1'b0;
                    l2_write <= 1'b0;
                end
            endcase
        end
    end

    assign i_resp     = (state == SERVE_I) & l2_resp;
    assign d_resp     = (state == SERVE_D) & l2_resp;
    assign line_rdata = l2_rdata;

`ifdef L2_ARB_PERF_EN
    logic i_wait;
    logic d_wait;

    assign i_wait = i_read & (state != SERVE_I) & !grant_i;
    assign d_wait = d_req & (state != SERVE_D) & !grant_d;

    // Grant and contention counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
            if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
            if (i_wait || d_wait)
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Directed scoreboard bench for l2_rr_arbiter (default build).
// Expected L2 transactions are queued at stimulus time and checked on issue.
module tb_l2_rr_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] line_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;

    l2_rr_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW),
        .FIXED_D_PRIO(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_read(i_read),
        .i_addr(i_addr),
        .i_resp(i_resp),
        .d_read(d_read),
        .d_write(d_write),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_resp(d_resp),
        .line_rdata(line_rdata),
        .l2_read(l2_read),
        .l2_write(l2_write),
        .l2_addr(l2_addr),
        .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata),
        .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit wr,
                        input logic [AW-1:0] a, input logic [LW-1:0] wd);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        sb.push_back(e);
    endtask

    // Model the L2: wait for the next command, compare it against the
    // scoreboard head, answer after lat cycles and check the owner's resp.
    task automatic serve(input int lat, input logic [LW-1:0] rdata,
                         input bit chg);
        exp_t e;
        int   w;
        bit   got;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e   = sb.pop_front();
        w   = 0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            w++;
            if (l2_read || l2_write) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $error("FAIL cmd_timeout observed=none expected=cmd");
            return;
        end
        chk("issue_wait", LW'(w), LW'(2));
        chk("l2_read", l2_read, !e.wr);
        chk("l2_write", l2_write, e.wr);
        chk("l2_addr", l2_addr, e.addr);
        if (e.wr) chk("l2_wdata", l2_wdata, e.wdata);
        if (chg) d_addr = 32'h0000_0300;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("addr_hold", l2_addr, e.addr);
            chk("no_early_resp", {i_resp, d_resp}, 2'b00);
        end
        @(posedge clk);
        #1;
        l2_resp  = 1'b1;
        l2_rdata = rdata;
        @(negedge clk);
        chk("i_resp", i_resp, !e.is_d);
        chk("d_resp", d_resp, e.is_d);
        chk("line_rdata", line_rdata, rdata);
        chk("addr_at_resp", l2_addr, e.addr);
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
    endtask

    // Both D commands at once is an illegal input combination.
    always @(negedge clk) begin
        if (!rst && d_read && d_write) begin
            failures++;
            $error("FAIL illegal_d_rw observed=11 expected=not_both");
        end
    end

    initial begin
        rst      = 1'b1;
        i_read   = 1'b0;
        i_addr   = '0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_rdata = '0;
        l2_resp  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_l2_read", l2_read, 1'b0);
        chk("rst_l2_write", l2_write, 1'b0);
        chk("rst_l2_addr", l2_addr, '0);
        chk("rst_l2_wdata", l2_wdata, '0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone I read, L2 answers 3 cycles after the command
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        push(1'b0, 1'b0, 32'h0000_0060, '0);
        serve(3, {8{32'hAAAA_AAAA}}, 1'b0);
        i_read = 1'b0;

        // Fresh reset, then simultaneous I read and D write
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0100;
        d_write = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = {8{32'h5555_5555}};
        push(1'b0, 1'b0, 32'h0000_0100, '0);
        push(1'b1, 1'b1, 32'h0000_0200, {8{32'h5555_5555}});
        serve(2, {8{32'h1234_5678}}, 1'b0);
        i_read = 1'b0;
        serve(3, {8{32'h9ABC_DEF0}}, 1'b1);
        d_write = 1'b0;

        // Sustained contention alternates I, D, I, D ...
        i_read = 1'b1;
        i_addr = 32'h0000_1000;
        d_read = 1'b1;
        d_addr = 32'h0000_2000;
        for (int t = 0; t < 8; t++) begin
            if (t % 2 == 0) push(1'b0, 1'b0, 32'h0000_1000, '0);
            else            push(1'b1, 1'b0, 32'h0000_2000, '0);
        end
        for (int t = 0; t < 8; t++) begin
            serve(1 + t % 3, {8{t + 32'hC0DE_0000}}, 1'b0);
            if (t == 6) i_read = 1'b0;
            if (t == 7) d_read = 1'b0;
        end

        // Async reset in the middle of a D write
        d_write = 1'b1;
        d_addr  = 32'h0000_0700;
        d_wdata = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_write", l2_write, 1'b1);
        chk("pre_rst_addr", l2_addr, 32'h0000_0700);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_write", l2_write, 1'b0);
        chk("mid_rst_addr", l2_addr, '0);
        chk("mid_rst_wdata", l2_wdata, '0);
        d_write = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        l2_resp = 1'b1;
        @(negedge clk);
        chk("stale_resp", {i_resp, d_resp}, 2'b00);
        chk("stale_cmd", {l2_read, l2_write}, 2'b00);
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
        @(negedge clk);
        chk("idle_after_stale", {l2_read, l2_write}, 2'b00);
        chk("sb_drained", LW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
